// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_arbiter
// Brief    : Two-requester round-robin APB master with 16-slot PSEL decode
//            and PREADY wait-state timeout.
// Revision : 1.0
// ============================================================================
module apb_master_arbiter #(
    parameter int SLOT_LSB = 24,
    parameter int TIMEOUT  = 255
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA0,
    output logic [31:0] RDATA1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [31:0] PADDR,
    output logic [15:0] PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETUP    = 2'd1,
        S_ACCESS   = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last;
    logic        r_gnt;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    logic        w_grant;
    logic        w_gnt_sel;
    logic        w_to_hit;
    logic        w_done_ok;
    logic        w_done_to;
    logic [31:0] w_cap_rdata;
    logic        w_cap_err;

    // On a tie the requester not served last wins; otherwise whoever asks.
    assign w_gnt_sel = (REQ0 && REQ1) ? ~r_last : REQ1;
    assign w_grant   = (r_state == S_IDLE) && (REQ0 || REQ1);
    assign w_to_hit  = (c_timeout != 16'd0) && (r_wait_cnt == c_timeout);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_ok   = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = S_COMPLETE;
                    w_done_ok   = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = S_COMPLETE;
                    w_done_to   = 1'b1;
                end
            end
            S_COMPLETE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Writes and timeouts both return zero read data; a timeout always errors.
    assign w_cap_rdata = (w_done_ok && !r_pwrite) ? PRDATA : 32'h0000_0000;
    assign w_cap_err   = w_done_ok ? PSLVERR : 1'b1;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_wait_cnt <= 16'd0;
            r_paddr    <= 32'h0000_0000;
            r_pwrite   <= 1'b0;
            r_pwdata   <= 32'h0000_0000;
            r_rdata0   <= 32'h0000_0000;
            r_rdata1   <= 32'h0000_0000;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt      <= w_gnt_sel;
                r_last     <= w_gnt_sel;
                r_wait_cnt <= 16'd0;
                if (w_gnt_sel) begin
                    r_paddr  <= ADDR1;
                    r_pwrite <= WR1;
                    r_pwdata <= WDATA1;
                end else begin
                    r_paddr  <= ADDR0;
                    r_pwrite <= WR0;
                    r_pwdata <= WDATA0;
                end
            end
            if ((r_state == S_ACCESS) && !PREADY && !w_to_hit) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_done_ok || w_done_to) begin
                if (r_gnt) begin
                    r_rdata1 <= w_cap_rdata;
                    r_err1   <= w_cap_err;
                end else begin
                    r_rdata0 <= w_cap_rdata;
                    r_err0   <= w_cap_err;
                end
            end
        end
    end

    assign PSEL    = ((r_state == S_SETUP) || (r_state == S_ACCESS))
                   ? (16'h0001 << r_paddr[SLOT_LSB +: 4]) : 16'h0000;
    assign PENABLE = (r_state == S_ACCESS);
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;
    assign ACK0    = (r_state == S_COMPLETE) && !r_gnt;
    assign ACK1    = (r_state == S_COMPLETE) && r_gnt;
    assign RDATA0  = r_rdata0;
    assign RDATA1  = r_rdata1;
    assign ERR0    = r_err0;
    assign ERR1    = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_arbiter
// Brief    : Directed self-checking bench for apb_master_arbiter (TIMEOUT = 4).
// Revision : 1.0
// ============================================================================
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        REQ0, REQ1, WR0, WR1;
    logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
    logic        ACK0, ACK1, ERR0, ERR1;
    logic [31:0] RDATA0, RDATA1;
    logic [31:0] PADDR;
    logic [15:0] PSEL;
    logic        PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.SLOT_LSB(24), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .ERR0(ERR0), .ERR1(ERR1),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Every task starts and ends just after a falling edge; the next rising
    // edge is "edge 0" and the cycle after edge k is "cycle k".
    task automatic do_reset();
        PRESETN = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETN = 1'b1;
    endtask

    task automatic test_reset();
        PRESETN = 1'b0;
        @(negedge PCLK);
        n_checks++;
        if ({PADDR, PSEL, PENABLE, PWRITE, PWDATA} !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_apb: got %h required 0", {PADDR, PSEL, PENABLE, PWRITE, PWDATA});
        end
        n_checks++;
        if ({ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_req: got %h required 0", {ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1});
        end
        PRESETN = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, ACK0, ACK1} !== 19'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h required 0", {PSEL, PENABLE, ACK0, ACK1});
        end
    endtask

    task automatic test_single_write();
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h0300_0010; WDATA0 = 32'hDEAD_BEEF;
        PREADY = 1'b1; PSLVERR = 1'b0;
        @(negedge PCLK); // cycle 1 SETUP
        n_checks++;
        if ({PSEL, PENABLE, ACK0} !== {16'h0008, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_setup psel/pen/ack: got %h required %h", {PSEL, PENABLE, ACK0}, {16'h0008, 2'b00});
        end
        n_checks++;
        if ({PADDR, PWRITE, PWDATA} !== {32'h0300_0010, 1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL wr_setup addr/dir/data: got %h", {PADDR, PWRITE, PWDATA});
        end
        @(negedge PCLK); // cycle 2 ACCESS
        n_checks++;
        if ({PSEL, PENABLE, ACK0} !== {16'h0008, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_access: got %h required %h", {PSEL, PENABLE, ACK0}, {16'h0008, 2'b10});
        end
        @(negedge PCLK); // cycle 3 COMPLETE
        n_checks++;
        if ({PSEL, PENABLE, ACK0, ACK1, ERR0} !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_ack: got %h required %h", {PSEL, PENABLE, ACK0, ACK1, ERR0}, {16'h0000, 4'b0100});
        end
        REQ0 = 1'b0;
        @(negedge PCLK); // cycle 4 IDLE
        n_checks++;
        if ({ACK0, RDATA0} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_after: got ack=%b rdata=%h required ack=0 rdata=0", ACK0, RDATA0);
        end
    endtask

    task automatic test_wait_read();
        REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 32'h0F00_0040; PREADY = 1'b0; PRDATA = 32'h0;
        @(negedge PCLK); // cycle 1
        n_checks++;
        if ({PSEL, PENABLE, PWRITE} !== {16'h8000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_setup: got %h required %h", {PSEL, PENABLE, PWRITE}, {16'h8000, 2'b00});
        end
        for (int c = 2; c <= 5; c++) begin
            @(negedge PCLK);
            n_checks++;
            if ({PSEL, PENABLE, ACK0} !== {16'h8000, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_wait cycle %0d: got %h required %h", c, {PSEL, PENABLE, ACK0}, {16'h8000, 2'b10});
            end
        end
        PREADY = 1'b1; PRDATA = 32'h1234_5678; // PREADY high during cycle 5
        @(negedge PCLK); // cycle 6
        n_checks++;
        if ({ACK0, RDATA0, ERR0, PENABLE} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_ack: got ack=%b rdata=%h err=%b pen=%b required 1/12345678/0/0", ACK0, RDATA0, ERR0, PENABLE);
        end
        REQ0 = 1'b0; PRDATA = 32'h0;
        @(negedge PCLK);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack;
        logic [15:0] exp_psel;
        do_reset();
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h0100_0000; WDATA0 = 32'h0000_00A0;
        REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 32'h0200_0004; WDATA1 = 32'h0000_00B1;
        PREADY = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge PCLK);
            exp_ack = {(c == 7 || c == 15), (c == 3 || c == 11)};
            n_checks++;
            if ({ACK1, ACK0} !== exp_ack) begin
                n_fail++;
                $display("FAIL rr_ack cycle %0d: got {ack1,ack0}=%b required %b", c, {ACK1, ACK0}, exp_ack);
            end
            if (c % 4 == 1) begin
                exp_psel = (c == 1 || c == 9) ? 16'h0002 : 16'h0004;
                n_checks++;
                if (PSEL !== exp_psel) begin
                    n_fail++;
                    $display("FAIL rr_psel cycle %0d: got %h required %h", c, PSEL, exp_psel);
                end
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_timeout();
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 32'h0300_0000; PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        @(negedge PCLK); // cycle 1
        for (int c = 2; c <= 6; c++) begin
            @(negedge PCLK);
            n_checks++;
            if ({PSEL, PENABLE, ACK1} !== {16'h0008, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL to_wait cycle %0d: got %h required %h", c, {PSEL, PENABLE, ACK1}, {16'h0008, 2'b10});
            end
        end
        @(negedge PCLK); // cycle 7
        n_checks++;
        if ({ACK1, ERR1, RDATA1, PSEL} !== {1'b1, 1'b1, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL to_ack: got ack=%b err=%b rdata=%h psel=%h required 1/1/0/0", ACK1, ERR1, RDATA1, PSEL);
        end
        REQ1 = 1'b0; PREADY = 1'b1; PRDATA = 32'h0;
        @(negedge PCLK);
    endtask

    task automatic test_slverr();
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h0500_0000; WDATA0 = 32'h0000_0055;
        PREADY = 1'b1; PSLVERR = 1'b1;
        repeat (3) @(negedge PCLK);
        n_checks++;
        if ({ACK0, ERR0} !== 2'b11) begin
            n_fail++;
            $display("FAIL slverr_ack: got ack=%b err=%b required 1/1", ACK0, ERR0);
        end
        REQ0 = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 32'h0600_0000; PRDATA = 32'hA5A5_0001;
        repeat (3) @(negedge PCLK);
        n_checks++;
        if ({ACK1, ERR1, RDATA1, ERR0} !== {1'b1, 1'b0, 32'hA5A5_0001, 1'b1}) begin
            n_fail++;
            $display("FAIL next_ok: got ack1=%b err1=%b rdata1=%h err0=%b required 1/0/a5a50001/1", ACK1, ERR1, RDATA1, ERR0);
        end
        REQ1 = 1'b0; PRDATA = 32'h0;
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 32'h0700_0000; WDATA0 = 32'h1111_2222; PREADY = 1'b0;
        repeat (3) @(negedge PCLK); // cycle 3, in ACCESS
        n_checks++;
        if ({PSEL, PENABLE} !== {16'h0080, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_access: got %h required %h", {PSEL, PENABLE}, {16'h0080, 1'b1});
        end
        PRESETN = 1'b0; REQ0 = 1'b0;
        #1;
        n_checks++;
        if ({PADDR, PSEL, PENABLE, PWRITE, PWDATA, ACK0, ACK1, ERR0, ERR1, RDATA0, RDATA1} !== 150'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got paddr=%h psel=%h pen=%b err0=%b rdata1=%h required all 0", PADDR, PSEL, PENABLE, ERR0, RDATA1);
        end
        REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 32'h0900_0000; WDATA1 = 32'h3333_4444; PREADY = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({ACK0, ACK1} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_no_ack: got %b required 00", {ACK0, ACK1});
        end
        PRESETN = 1'b1;
        @(negedge PCLK); // cycle 1
        n_checks++;
        if ({PSEL, PADDR, PWDATA} !== {16'h0200, 32'h0900_0000, 32'h3333_4444}) begin
            n_fail++;
            $display("FAIL post_reset_grant: got psel=%h paddr=%h required 0200/09000000", PSEL, PADDR);
        end
        repeat (2) @(negedge PCLK); // cycle 3
        n_checks++;
        if ({ACK1, ACK0} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_ack: got {ack1,ack0}=%b required 10", {ACK1, ACK0});
        end
        REQ1 = 1'b0;
        @(negedge PCLK);
    endtask

    initial begin
        PRESETN = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0; WR0 = 1'b0; WR1 = 1'b0;
        ADDR0 = 32'h0; ADDR1 = 32'h0; WDATA0 = 32'h0; WDATA1 = 32'h0;
        PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
        test_reset();
        test_single_write();
        test_wait_read();
        test_round_robin();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master for the BFM/peripheral subsystem. It accepts word transfers from two independent requesters (the BFM-driven bridge path and a second on-chip master) over a simple request/acknowledge handshake, and arbitrates between them round-robin. It sequences the APB SETUP/ACCESS phases, decodes a 16-slot PSEL, absorbs PREADY wait states and enforces a wait-state timeout.

## Interface
Parameters:
- SLOT_LSB, 24, lowest PADDR bit of the 4-bit slot field that selects PSEL[15:0].
- TIMEOUT, 255, maximum PREADY-low ACCESS cycles before forced error completion; 0 disables the timeout. Range 0..65535.

Ports:
- PCLK  in  1  sole clock; all logic is rising-edge.
- PRESETN  in  1  asynchronous, active-low reset.
- REQ0 / REQ1  in  1  transfer request; held high until ACKn is sampled high.
- WR0 / WR1  in  1  1 = write, 0 = read; held stable while REQn is high.
- ADDR0 / ADDR1  in  32  byte address; stable while REQn is high.
- WDATA0 / WDATA1  in  32  write data; stable while REQn is high.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA0 / RDATA1  out  32  read data; valid while ACKn = 1.
- ERR0 / ERR1  out  1  PSLVERR or timeout; valid while ACKn = 1.
- PADDR  out  32  APB address.
- PSEL  out  16  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

## Operation
- The state machine has four states: IDLE, SETUP, ACCESS and COMPLETE.
- IDLE:
  - If any REQn is high, grant it, latch WRn/ADDRn/WDATAn into the APB output registers and go to SETUP.
  - If both REQn are high, grant the requester not granted last. The LAST pointer resets to 1, so requester 0 wins the first tie.
  - Update LAST on every grant.
- SETUP:
  - PSEL[PADDR[SLOT_LSB+3:SLOT_LSB]] = 1 and PENABLE = 0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL is held and PENABLE = 1.
  - If PREADY = 1: capture PRDATA (read) or 0 (write) into RDATAg, capture PSLVERR into ERRg, and go to COMPLETE.
  - Else if TIMEOUT ≠ 0 and the wait counter = TIMEOUT: RDATAg = 0, ERRg = 1, go to COMPLETE.
  - Else increment the 16-bit wait counter. The counter clears on entry to SETUP.
- COMPLETE:
  - PSEL = 0, PENABLE = 0 and ACKg = 1 for exactly one cycle; no arbitration takes place this cycle.
  - Go to IDLE.
  - The requester drops REQ at the edge where it samples ACK = 1, so the finished request is never re-granted.
- PADDR, PWRITE and PWDATA hold their last latched values outside a transfer. PWDATA carries latched WDATA even on reads.
- RDATAn and ERRn hold their values until that requester's next completion.
- A requester withdrawing REQ before being granted is permitted. Once granted, the transfer completes regardless of REQ.

## Timing
- Reset values (asynchronous, applied immediately when PRESETN is low): PADDR = 0, PSEL = 0, PENABLE = 0, PWRITE = 0, PWDATA = 0, ACK0/1 = 0, RDATA0/1 = 0, ERR0/1 = 0; state = IDLE; LAST = 1; wait counter = 0.
- Zero-wait transfer:
  - REQ sampled in IDLE at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2 (PREADY = 1).
  - ACK high in cycle 3. REQ-to-ACK latency is 3 cycles.
- Each PREADY-low ACCESS cycle adds one cycle.
- Timeout completion occurs after TIMEOUT+1 ACCESS cycles; ACK follows one cycle later.
- Back-to-back throughput is one transfer per 4 cycles. There is an IDLE cycle between COMPLETE and the next SETUP.
- PSEL asserts in SETUP and PENABLE one cycle later; both deassert together on the edge leaving ACCESS.
- Reset asserted mid-transfer aborts the transfer immediately with no ACK. After release the block starts in IDLE.

## Test plan
- Single write, REQ0, ADDR0 = 0x0300_0010, WDATA0 = 0xDEADBEEF, PREADY = 1 -> PSEL = 0x0008 for cycles 1–2, PENABLE high in cycle 2 only, ACK0 in cycle 3, ERR0 = 0.
- Read from slot 15 with 3 PREADY-low cycles, PRDATA = 0x1234_5678 -> ACCESS lasts 4 cycles, ACK0 in cycle 6, RDATA0 = 0x1234_5678.
- REQ0 and REQ1 both held continuously for 4 transfers -> grant order 0, 1, 0, 1; each ACK is 4 cycles apart.
- TIMEOUT = 4, PREADY stuck at 0 -> forced completion after 5 ACCESS cycles, ERRn = 1, RDATAn = 0.
- PSLVERR = 1 with PREADY = 1 -> ERRn = 1 in the ACK cycle. The next requester's transfer then completes with ERR = 0.
- PRESETN pulsed low during ACCESS -> all outputs return to their reset values at once and no ACK is issued. After release with REQ1 held, the first grant goes to requester 1.
